// File: rtl/range_stat_acc.sv
// Streaming per-channel max/min/sum accumulator over a fixed mini-batch.
// Results are held behind a valid/ready handshake while the input is back-pressured.
module range_stat_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int MINI_BATCH = 64,
  parameter int ADDR_WIDTH = $clog2(MINI_BATCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_in,
  input  logic                  data_valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_ready_out,
  output logic                  stat_valid_out,
  input  logic                  stat_ready_in,
  output logic [DATA_WIDTH-1:0] max_out,
  output logic [DATA_WIDTH-1:0] min_out,
  output logic [DATA_WIDTH-1:0] sum_out,
  output logic [ADDR_WIDTH:0]   count_out
);

  localparam int ACC_W = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(MINI_BATCH - 1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ADDR_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ADDR_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                        state_r, state_nxt_s;
  logic [ADDR_WIDTH:0]           count_r, count_nxt_s;
  logic signed [DATA_WIDTH-1:0]  max_r, min_r, max_nxt_s, min_nxt_s;
  logic signed [ACC_W-1:0]       acc_r, acc_nxt_s;
  logic signed [DATA_WIDTH-1:0]  x_s;
  logic signed [ACC_W-1:0]       x_ext_s;
  logic                          accept_s;

  // Clamp the wide accumulator into the output range.
  function automatic logic [DATA_WIDTH-1:0] sat_sum(input logic signed [ACC_W-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    if (v > SAT_HI) begin
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (v < SAT_LO) begin
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  assign x_s            = data_in;
  assign x_ext_s        = {{ADDR_WIDTH{x_s[DATA_WIDTH-1]}}, x_s};
  assign data_ready_out = (state_r == ST_ACC) && !rst;
  assign accept_s       = data_valid_in && data_ready_out && !clear_in;
  assign count_out      = count_r;

  // Next-state, sample counter and running statistics.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    max_nxt_s   = max_r;
    min_nxt_s   = min_r;
    acc_nxt_s   = acc_r;
    case (state_r)
      ST_ACC: begin
        if (clear_in) begin
          count_nxt_s = CNT_ZERO;
        end else if (accept_s) begin
          count_nxt_s = count_r + CNT_ONE;
          // The first sample seeds all three statistics.
          if (count_r == CNT_ZERO) begin
            max_nxt_s = x_s;
            min_nxt_s = x_s;
            acc_nxt_s = x_ext_s;
          end else begin
            max_nxt_s = (x_s > max_r) ? x_s : max_r;
            min_nxt_s = (x_s < min_r) ? x_s : min_r;
            acc_nxt_s = acc_r + x_ext_s;
          end
          if (count_r == LAST_CNT) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_ACC;
          end
        end else begin
          count_nxt_s = count_r;
        end
      end
      ST_HOLD: begin
        if (clear_in || stat_ready_in) begin
          state_nxt_s = ST_ACC;
          count_nxt_s = CNT_ZERO;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_ACC;
        count_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // State, statistics and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_ACC;
      count_r        <= CNT_ZERO;
      max_r          <= DATA_ZERO;
      min_r          <= DATA_ZERO;
      acc_r          <= {ACC_W{1'b0}};
      stat_valid_out <= 1'b0;
      max_out        <= DATA_ZERO;
      min_out        <= DATA_ZERO;
      sum_out        <= DATA_ZERO;
    end else begin
      state_r        <= state_nxt_s;
      count_r        <= count_nxt_s;
      max_r          <= max_nxt_s;
      min_r          <= min_nxt_s;
      acc_r          <= acc_nxt_s;
      stat_valid_out <= (state_nxt_s == ST_HOLD);
      if ((state_r == ST_ACC) && (state_nxt_s == ST_HOLD)) begin
        max_out <= max_nxt_s;
        min_out <= min_nxt_s;
        sum_out <= sat_sum(acc_nxt_s);
      end else if (state_nxt_s == ST_ACC) begin
        max_out <= DATA_ZERO;
        min_out <= DATA_ZERO;
        sum_out <= DATA_ZERO;
      end else begin
        max_out <= max_out;
        min_out <= min_out;
        sum_out <= sum_out;
      end
    end
  end

endmodule

// File: tb/tb_range_stat_acc.sv
// Directed bench for range_stat_acc: a MINI_BATCH=4 instance for protocol cases
// and a default-parameter instance for saturation.
module tb_range_stat_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear4, valid4, sready4, ready4, svalid4;
  logic [15:0] data4, max4, min4, sum4;
  logic [2:0]  count4;
  logic        clear64, valid64, sready64, ready64, svalid64;
  logic [15:0] data64, max64, min64, sum64;
  logic [6:0]  count64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  range_stat_acc #(.DATA_WIDTH(16), .MINI_BATCH(4)) dut4 (
    .clk(clk), .rst(rst), .clear_in(clear4), .data_valid_in(valid4), .data_in(data4),
    .data_ready_out(ready4), .stat_valid_out(svalid4), .stat_ready_in(sready4),
    .max_out(max4), .min_out(min4), .sum_out(sum4), .count_out(count4)
  );

  range_stat_acc #(.DATA_WIDTH(16), .MINI_BATCH(64)) dut64 (
    .clk(clk), .rst(rst), .clear_in(clear64), .data_valid_in(valid64), .data_in(data64),
    .data_ready_out(ready64), .stat_valid_out(svalid64), .stat_ready_in(sready64),
    .max_out(max64), .min_out(min64), .sum_out(sum64), .count_out(count64)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int v, input int mx, input int mn, input int sm, input int c, input int rdy);
    chk({tag, " valid"}, int'(svalid4), v);
    chk({tag, " max"}, int'($signed(max4)), mx);
    chk({tag, " min"}, int'($signed(min4)), mn);
    chk({tag, " sum"}, int'($signed(sum4)), sm);
    chk({tag, " count"}, int'(count4), c);
    chk({tag, " ready"}, int'(ready4), rdy);
  endtask

  initial begin
    rst = 1'b1;
    clear4 = 1'b0; valid4 = 1'b0; sready4 = 1'b0; data4 = 16'd0;
    clear64 = 1'b0; valid64 = 1'b0; sready64 = 1'b0; data64 = 16'd0;
    tick(); tick();
    chk4("reset", 0, 0, 0, 0, 0, 0);
    chk("reset ready64", int'(ready64), 0);
    rst = 1'b0;
    tick();
    chk("post-reset ready", int'(ready4), 1);

    // Back-to-back batch 3,-5,7,1 with downstream always ready
    sready4 = 1'b1; valid4 = 1'b1; data4 = 16'd3;
    tick(); chk("b2b count1", int'(count4), 1);
    data4 = 16'(-5); tick();
    data4 = 16'd7;   tick();
    data4 = 16'd1;   tick();
    valid4 = 1'b0;
    chk4("b2b hold", 1, 7, -5, 6, 4, 0);
    tick();
    chk4("b2b after", 0, 0, 0, 0, 0, 1);

    // Backpressure: batch 2,4,6,8 held for 10 cycles under toggling input
    sready4 = 1'b0; valid4 = 1'b1;
    data4 = 16'd2; tick();
    data4 = 16'd4; tick();
    data4 = 16'd6; tick();
    data4 = 16'd8; tick();
    for (int i = 0; i < 10; i++) begin
      valid4 = ~valid4;
      data4  = 16'($urandom);
      tick();
      chk4("bp hold", 1, 8, 2, 20, 4, 0);
    end
    valid4 = 1'b0; sready4 = 1'b1;
    tick();
    sready4 = 1'b0;
    chk4("bp release", 0, 0, 0, 0, 0, 1);
    valid4 = 1'b1; data4 = 16'd5;
    tick();
    valid4 = 1'b0;
    chk("bp next count", int'(count4), 1);
    clear4 = 1'b1; tick(); clear4 = 1'b0;
    chk("idle clear count", int'(count4), 0);

    // Gapped input -1..-4 with two idle cycles between samples
    for (int i = 0; i < 4; i++) begin
      valid4 = 1'b1; data4 = 16'(-(i + 1));
      tick();
      valid4 = 1'b0;
      chk("gap count", int'(count4), i + 1);
      tick(); tick();
    end
    chk4("gap hold", 1, -1, -4, -10, 4, 0);
    sready4 = 1'b1; tick(); sready4 = 1'b0;
    chk("gap release valid", int'(svalid4), 0);

    // clear_in with the third sample drops it and restarts the batch
    valid4 = 1'b1;
    data4 = 16'd1; tick();
    data4 = 16'd2; tick();
    data4 = 16'd99; clear4 = 1'b1; tick();
    clear4 = 1'b0;
    chk("clear count", int'(count4), 0);
    data4 = 16'd10; tick();
    data4 = 16'd20; tick();
    data4 = 16'd30; tick();
    data4 = 16'd40; tick();
    valid4 = 1'b0;
    chk4("clear hold", 1, 40, 10, 100, 4, 0);

    // clear_in in HOLD drops results without a handshake
    clear4 = 1'b1; tick(); clear4 = 1'b0;
    chk4("hold clear", 0, 0, 0, 0, 0, 1);

    // rst for one cycle while in HOLD
    valid4 = 1'b1;
    data4 = 16'd9; tick(); tick(); tick(); tick();
    valid4 = 1'b0;
    chk("pre-rst valid", int'(svalid4), 1);
    rst = 1'b1; tick();
    chk4("rst in hold", 0, 0, 0, 0, 0, 0);
    rst = 1'b0; tick();
    chk("rst release ready", int'(ready4), 1);

    // Default parameters: positive saturation
    valid64 = 1'b1; data64 = 16'h7FFF;
    for (int i = 0; i < 64; i++) tick();
    valid64 = 1'b0;
    chk("sat+ valid", int'(svalid64), 1);
    chk("sat+ max", int'($signed(max64)), 32767);
    chk("sat+ min", int'($signed(min64)), 32767);
    chk("sat+ sum", int'($signed(sum64)), 32767);
    chk("sat+ count", int'(count64), 64);
    sready64 = 1'b1; tick(); sready64 = 1'b0;
    chk("sat+ release", int'(svalid64), 0);

    // Default parameters: negative saturation
    valid64 = 1'b1; data64 = 16'h8000;
    for (int i = 0; i < 64; i++) tick();
    valid64 = 1'b0;
    chk("sat- valid", int'(svalid64), 1);
    chk("sat- max", int'($signed(max64)), -32768);
    chk("sat- min", int'($signed(min64)), -32768);
    chk("sat- sum", int'($signed(sum64)), -32768);
    chk("sat- count", int'(count64), 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
